apb_accel_ctrl_mc: RTL and testbench
====================================

// Module: apb_accel_ctrl_mc
// PURPOSE
//  APB control/status slave for NUM_CH independent accelerator channels (pool/conv engines).
//  Per channel: self-clearing start pulse, busy/done FSM, sticky W1C done, internal cycle
//  counter, and config registers locked while the channel is busy. Sits between the CPU APB
//  bus and the engines, one start/done pair per engine.
// PARAMETERS
//  NUM_CH  4   number of channels (1..16); CH_AW = max(1,$clog2(NUM_CH)) is a localparam
//  DIM_W   9   width of cfg_width/cfg_length/cfg_height per channel
//  SIZE_W  11  width of cfg_size per channel
//  CNT_W   32  cycle counter width (<=32)
// PORTS
//  PCLK       in   1               APB clock, sole clock
//  PRESET     in   1               synchronous, active-high reset
//  PADDR      in   32              APB address
//  PSEL       in   1               APB select
//  PENABLE    in   1               APB enable
//  PWRITE     in   1               APB write enable
//  PWDATA     in   32              APB write data
//  PRDATA     out  32              APB read data
//  PREADY     out  1               constant 1 (no wait states)
//  acc_done   in   NUM_CH          per-channel done pulse/level from engine
//  acc_start  out  NUM_CH          per-channel one-cycle start pulse
//  acc_busy   out  NUM_CH          channel in RUN state
//  cfg_width  out  NUM_CH*DIM_W    packed, ch0 in LSBs; same packing for the three below
//  cfg_length out  NUM_CH*DIM_W
//  cfg_height out  NUM_CH*DIM_W
//  cfg_size   out  NUM_CH*SIZE_W
//  irq        out  1               OR of (done_sticky & irq_en) over channels
// BEHAVIOUR
//  Decode: ch=PADDR[CH_AW+4:5], off=PADDR[4:2], PADDR[1:0] ignored; hit only if
//   PADDR[31:CH_AW+5]==0 and ch<NUM_CH. Miss: read 0, write ignored.
//  Map per ch (base ch*0x20): 0x00 CTRL W:b0=start R:b0=busy | 0x04 STATUS b0=done_sticky W1C
//   | 0x08 CYCLES RO | 0x0C width | 0x10 length | 0x14 height | 0x18 size | 0x1C IRQ_EN b0.
//   Read data zero-extended; unused bits read 0; writes to RO offsets ignored.
//  Write commits at the posedge with PSEL&PENABLE&PWRITE. Read: PRDATA captured at posedge
//   with PSEL&~PENABLE&~PWRITE (else captured 0); PRDATA = captured value only while
//   PSEL&PENABLE&~PWRITE, else 0. Read of CYCLES returns the value at the setup edge.
//  Reset: all outputs 0 except PREADY=1; all regs 0; every FSM in IDLE.
//  FSM per ch: IDLE --(CTRL write b0=1)--> RUN; RUN --(acc_done sampled 1)--> IDLE.
//   Entry to RUN: acc_start=1 for exactly the next cycle, acc_busy=1 same cycle, counter=0.
//   RUN: counter +1 every edge, saturates at all-ones; the edge sampling acc_done also counts,
//   so done sampled k edges after the acc_start cycle gives CYCLES=k. done_sticky set same edge.
//   CTRL start write in RUN: ignored. acc_done in IDLE: ignored (no sticky set).
//   Start in IDLE leaves done_sticky unchanged (SW clears it).
//  Config regs: writes while acc_busy=1 ignored (locked); cfg_* outputs are the registers.
//  Simultaneous W1C of done and hardware set in same edge: set wins, done_sticky=1.
//  Counter holds after RUN until next start. Reset mid-RUN: FSM IDLE, no acc_start, counter 0.
// CONFIGURATION
//  APB_ACCEL_IRQ_EN defined: IRQ_EN regs exist, irq registered (1-cycle after sticky set).
//  Not defined: IRQ_EN reads 0, writes ignored, irq tied 0; no IRQ_EN flops.
// TESTING
//  Reset: PRESET=1 2 cycles -> all outputs 0, PREADY=1, any register read =0.
//  Write 0x0C=0x1FF, 0x18=0x7FF on ch1 (0x2C,0x38) -> cfg_width[17:9]=0x1FF,
//   cfg_size[21:11]=0x7FF; ch0 fields unchanged.
//  Write 0x40 b0=1 (ch2), drive acc_done[2] 10 edges after acc_start[2] -> acc_start[2] one
//   cycle, busy then IDLE, read 0x48=10, 0x44=1; write 0x44=1 -> reads 0.
//  During ch2 RUN: write 0x4C=5 and 0x40=1 -> width unchanged, no second start pulse.
//  W1C 0x04 on the edge acc_done[0] sampled -> done_sticky=1; with APB_ACCEL_IRQ_EN and
//   IRQ_EN=1 irq=1 next cycle; without the macro irq stays 0 and 0x1C reads 0.
//  NUM_CH=3: read 0x60/0x400 -> 0; write 0x60 b0=1 -> no acc_start; PRESET mid-RUN -> IDLE.

Source files
------------

// File: rtl/apb_accel_ctrl_mc_if.sv
// APB bus bundle for the accelerator control block.
// The master drives the request; the slave returns read data and ready.
interface apb_accel_ctrl_mc_if;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_accel_ctrl_mc.sv
// APB control/status slave for NUM_CH accelerator channels: start pulse, busy/done FSM,
// sticky W1C done, cycle counter and busy-locked config. Optional macro: APB_ACCEL_IRQ_EN.
module apb_accel_ctrl_mc #(
  parameter int NUM_CH = 4,
  parameter int DIM_W  = 9,
  parameter int SIZE_W = 11,
  parameter int CNT_W  = 32
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  apb_accel_ctrl_mc_if.slave       apb,
  input  logic [NUM_CH-1:0]        acc_done,
  output logic [NUM_CH-1:0]        acc_start,
  output logic [NUM_CH-1:0]        acc_busy,
  output logic [NUM_CH*DIM_W-1:0]  cfg_width,
  output logic [NUM_CH*DIM_W-1:0]  cfg_length,
  output logic [NUM_CH*DIM_W-1:0]  cfg_height,
  output logic [NUM_CH*SIZE_W-1:0] cfg_size,
  output logic                     irq
);

  localparam int CH_AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  logic [CH_AW-1:0]  ch;
  logic [2:0]        off;
  logic              hit;
  logic              wr_acc;
  logic              rd_setup;
  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] ch_wr;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [NUM_CH-1:0] start_q, start_d;
  logic [NUM_CH-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [DIM_W-1:0]  width_q [NUM_CH];
  logic [DIM_W-1:0]  width_d [NUM_CH];
  logic [DIM_W-1:0]  length_q [NUM_CH];
  logic [DIM_W-1:0]  length_d [NUM_CH];
  logic [DIM_W-1:0]  height_q [NUM_CH];
  logic [DIM_W-1:0]  height_d [NUM_CH];
  logic [SIZE_W-1:0] size_q [NUM_CH];
  logic [SIZE_W-1:0] size_d [NUM_CH];
  logic [31:0]       rd_val;
  logic [31:0]       rdata_q, rdata_d;

`ifdef APB_ACCEL_IRQ_EN
  logic [NUM_CH-1:0] irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
`endif

  // Address bits below the word and above the data width carry no meaning here.
  logic unused_bits;
  assign unused_bits = &{1'b0, apb.PADDR[1:0], apb.PWDATA};

  assign ch       = apb.PADDR[CH_AW+4:5];
  assign off      = apb.PADDR[4:2];
  assign hit      = (apb.PADDR[31:CH_AW+5] == '0) && (32'(ch) < NUM_CH);
  assign wr_acc   = apb.PSEL & apb.PENABLE & apb.PWRITE & hit;
  assign rd_setup = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;

  always_comb begin
    ch_sel = '0;
    ch_wr  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i] = hit && (32'(ch) == i);
      ch_wr[i]  = wr_acc && ch_sel[i];
    end
  end

  // Channel FSM, start pulse, cycle counter and sticky done.
  always_comb begin
    start_d  = '0;
    sticky_d = sticky_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (ch_wr[i] && off == 3'd0 && apb.PWDATA[0]) begin
            state_d[i] = RUN;
            start_d[i] = 1'b1;
            cnt_d[i]   = '0;
          end
        end
        RUN: begin
          if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
          if (acc_done[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
      if (ch_wr[i] && off == 3'd1 && apb.PWDATA[0]) sticky_d[i] = 1'b0;
      // Hardware completion beats a coincident software clear.
      if (state_q[i] == RUN && acc_done[i]) sticky_d[i] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      width_d[i]  = width_q[i];
      length_d[i] = length_q[i];
      height_d[i] = height_q[i];
      size_d[i]   = size_q[i];
      if (ch_wr[i] && state_q[i] != RUN) begin
        case (off)
          3'd3:    width_d[i]  = apb.PWDATA[DIM_W-1:0];
          3'd4:    length_d[i] = apb.PWDATA[DIM_W-1:0];
          3'd5:    height_d[i] = apb.PWDATA[DIM_W-1:0];
          3'd6:    size_d[i]   = apb.PWDATA[SIZE_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel[i]) begin
        case (off)
          3'd0:    rd_val = {31'b0, state_q[i] == RUN};
          3'd1:    rd_val = {31'b0, sticky_q[i]};
          3'd2:    rd_val = 32'(cnt_q[i]);
          3'd3:    rd_val = 32'(width_q[i]);
          3'd4:    rd_val = 32'(length_q[i]);
          3'd5:    rd_val = 32'(height_q[i]);
          3'd6:    rd_val = 32'(size_q[i]);
`ifdef APB_ACCEL_IRQ_EN
          3'd7:    rd_val = {31'b0, irq_en_q[i]};
`endif
          default: rd_val = '0;
        endcase
      end
    end
    rdata_d = rd_setup ? rd_val : '0;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      start_q  <= '0;
      sticky_q <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= IDLE;
        cnt_q[i]    <= '0;
        width_q[i]  <= '0;
        length_q[i] <= '0;
        height_q[i] <= '0;
        size_q[i]   <= '0;
      end
    end else begin
      start_q  <= start_d;
      sticky_q <= sticky_d;
      rdata_q  <= rdata_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        width_q[i]  <= width_d[i];
        length_q[i] <= length_d[i];
        height_q[i] <= height_d[i];
        size_q[i]   <= size_d[i];
      end
    end
  end

`ifdef APB_ACCEL_IRQ_EN
  // irq follows the registered sticky bits, so it rises one cycle after done lands.
  always_comb begin
    irq_en_d = irq_en_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_wr[i] && off == 3'd7) irq_en_d[i] = apb.PWDATA[0];
    end
    irq_d = |(sticky_q & irq_en_q);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      acc_busy[i] = (state_q[i] == RUN);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_pack
      assign cfg_width[g*DIM_W +: DIM_W]   = width_q[g];
      assign cfg_length[g*DIM_W +: DIM_W]  = length_q[g];
      assign cfg_height[g*DIM_W +: DIM_W]  = height_q[g];
      assign cfg_size[g*SIZE_W +: SIZE_W]  = size_q[g];
    end
  endgenerate

  assign acc_start  = start_q;
  assign apb.PREADY = 1'b1;
  assign apb.PRDATA = (apb.PSEL & apb.PENABLE & ~apb.PWRITE) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_apb_accel_ctrl_mc.sv
// Self-checking bench for apb_accel_ctrl_mc with three channels: register table plus
// hand-timed start/done, lock, W1C-vs-set, miss decode and mid-run reset sequences.
module tb_apb_accel_ctrl_mc;
  localparam int NCH = 3;

  logic              pclk;
  logic              preset;
  logic [NCH-1:0]    acc_done;
  logic [NCH-1:0]    acc_start;
  logic [NCH-1:0]    acc_busy;
  logic [NCH*9-1:0]  cfg_width;
  logic [NCH*9-1:0]  cfg_length;
  logic [NCH*9-1:0]  cfg_height;
  logic [NCH*11-1:0] cfg_size;
  logic              irq;

  apb_accel_ctrl_mc_if bus();

  apb_accel_ctrl_mc #(.NUM_CH(NCH), .DIM_W(9), .SIZE_W(11), .CNT_W(32)) dut (
    .PCLK(pclk), .PRESET(preset), .apb(bus.slave), .acc_done(acc_done),
    .acc_start(acc_start), .acc_busy(acc_busy), .cfg_width(cfg_width),
    .cfg_length(cfg_length), .cfg_height(cfg_height), .cfg_size(cfg_size), .irq(irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int total = 0;
  int bad = 0;
  int st_cnt [NCH];
  logic [31:0] exp_q [$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [$];

`ifdef APB_ACCEL_IRQ_EN
  localparam logic [31:0] IRQ_ON = 32'd1;
`else
  localparam logic [31:0] IRQ_ON = 32'd0;
`endif

  always @(negedge pclk) begin
    for (int i = 0; i < NCH; i++) if (acc_start[i]) st_cnt[i]++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // All bus tasks start and return on a falling edge.
  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    bus.PADDR = a; bus.PWDATA = d; bus.PWRITE = 1'b1; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    @(negedge pclk);
    bus.PENABLE = 1'b1;
    @(negedge pclk);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    bus.PADDR = a; bus.PWRITE = 1'b0; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    @(negedge pclk);
    bus.PENABLE = 1'b1;
    #1;
    chk(nm, bus.PRDATA, exp_q.pop_front());
    chk({nm, "_ready"}, 32'(bus.PREADY), 32'd1);
    @(negedge pclk);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    #1;
    chk({nm, "_idle0"}, bus.PRDATA, 32'd0);
    @(negedge pclk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int b;
    for (int i = 0; i < NCH; i++) st_cnt[i] = 0;
    preset = 1'b1; acc_done = '0;
    bus.PADDR = '0; bus.PWDATA = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_start", 32'(acc_start), 32'd0);
    chk("rst_busy", 32'(acc_busy), 32'd0);
    chk("rst_width", 32'(cfg_width), 32'd0);
    chk("rst_size", cfg_size[31:0], 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ready", 32'(bus.PREADY), 32'd1);
    preset = 1'b0;
    @(negedge pclk);

    tbl.push_back('{1'b0, 32'h00, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 32'h08, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 32'h2C, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 32'h1C, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 32'h2C, 32'h1FF, 32'h0});
    tbl.push_back('{1'b1, 32'h38, 32'h7FF, 32'h0});
    tbl.push_back('{1'b0, 32'h2C, 32'h0, 32'h1FF});
    tbl.push_back('{1'b0, 32'h38, 32'h0, 32'h7FF});
    tbl.push_back('{1'b0, 32'h0C, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 32'h18, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 32'h0C, 32'hFFFFFE05, 32'h0});
    tbl.push_back('{1'b0, 32'h0C, 32'h0, 32'h005});
    tbl.push_back('{1'b1, 32'h34, 32'hABC, 32'h0});
    tbl.push_back('{1'b0, 32'h34, 32'h0, 32'h0BC});
    tbl.push_back('{1'b1, 32'h08, 32'h55, 32'h0});
    tbl.push_back('{1'b0, 32'h08, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 32'h6C, 32'h77, 32'h0});
    tbl.push_back('{1'b0, 32'h60, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 32'h400, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 32'h40C, 32'h33, 32'h0});
    tbl.push_back('{1'b0, 32'h0C, 32'h0, 32'h005});
    tbl.push_back('{1'b0, 32'h2E, 32'h0, 32'h1FF});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) apb_wr(tbl[i].addr, tbl[i].data);
      else apb_rd(tbl[i].addr, tbl[i].exp, $sformatf("vec%0d", i));
    end
    chk("cfg_w_ch1", 32'(cfg_width[17:9]), 32'h1FF);
    chk("cfg_s_ch1", 32'(cfg_size[21:11]), 32'h7FF);
    chk("cfg_w_ch0", 32'(cfg_width[8:0]), 32'h005);
    chk("cfg_s_ch0", 32'(cfg_size[10:0]), 32'h0);
    chk("cfg_h_ch1", 32'(cfg_height[17:9]), 32'h0BC);

    // ch2: done sampled 10 edges after the start cycle.
    b = st_cnt[2];
    apb_wr(32'h40, 32'h1);
    chk("ch2_start_hi", 32'(acc_start[2]), 32'd1);
    chk("ch2_busy_hi", 32'(acc_busy[2]), 32'd1);
    @(negedge pclk);
    chk("ch2_start_lo", 32'(acc_start[2]), 32'd0);
    chk("ch2_busy_run", 32'(acc_busy[2]), 32'd1);
    repeat (8) @(negedge pclk);
    acc_done[2] = 1'b1;
    @(negedge pclk);
    acc_done[2] = 1'b0;
    chk("ch2_busy_lo", 32'(acc_busy[2]), 32'd0);
    chk("ch2_pulses", 32'(st_cnt[2] - b), 32'd1);
    apb_rd(32'h48, 32'd10, "ch2_cycles");
    apb_rd(32'h44, 32'd1, "ch2_sticky");
    apb_wr(32'h44, 32'h1);
    apb_rd(32'h44, 32'd0, "ch2_w1c");
    apb_rd(32'h48, 32'd10, "ch2_cyc_hold");
    apb_wr(32'h4C, 32'h33);

    // ch2 locked config and ignored restart while running.
    b = st_cnt[2];
    apb_wr(32'h40, 32'h1);
    apb_wr(32'h4C, 32'h5);
    apb_wr(32'h40, 32'h1);
    chk("ch2_one_pulse", 32'(st_cnt[2] - b), 32'd1);
    chk("ch2_lock_out", 32'(cfg_width[26:18]), 32'h33);
    chk("ch2_still_busy", 32'(acc_busy[2]), 32'd1);
    acc_done[2] = 1'b1;
    @(negedge pclk);
    acc_done[2] = 1'b0;
    chk("ch2_done2", 32'(acc_busy[2]), 32'd0);
    apb_rd(32'h4C, 32'h33, "ch2_lock_rd");

    // ch0: W1C coinciding with the hardware done edge.
    apb_wr(32'h1C, 32'h1);
    apb_wr(32'h00, 32'h1);
    bus.PADDR = 32'h04; bus.PWDATA = 32'h1; bus.PWRITE = 1'b1; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    @(negedge pclk);
    bus.PENABLE = 1'b1; acc_done[0] = 1'b1;
    @(negedge pclk);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; acc_done[0] = 1'b0;
    chk("ch0_busy_lo", 32'(acc_busy[0]), 32'd0);
    chk("ch0_irq_early", 32'(irq), 32'd0);
    @(negedge pclk);
    chk("ch0_irq", 32'(irq), IRQ_ON);
    apb_rd(32'h04, 32'd1, "ch0_set_wins");
    apb_rd(32'h1C, IRQ_ON, "ch0_irqen_rd");
    apb_wr(32'h04, 32'h1);
    @(negedge pclk);
    chk("ch0_irq_clr", 32'(irq), 32'd0);
    apb_rd(32'h04, 32'd0, "ch0_sticky_clr");

    // acc_done while idle must not set sticky.
    acc_done[1] = 1'b1;
    @(negedge pclk);
    acc_done[1] = 1'b0;
    apb_rd(32'h24, 32'd0, "ch1_idle_done");

    // Start to a non-existent channel.
    b = st_cnt[0] + st_cnt[1] + st_cnt[2];
    apb_wr(32'h60, 32'h1);
    chk("miss_start", 32'(acc_start), 32'd0);
    @(negedge pclk);
    chk("miss_busy", 32'(acc_busy), 32'd0);
    chk("miss_pulses", 32'(st_cnt[0] + st_cnt[1] + st_cnt[2] - b), 32'd0);

    // Reset in the middle of a ch1 run.
    apb_wr(32'h20, 32'h1);
    repeat (3) @(negedge pclk);
    chk("ch1_run", 32'(acc_busy[1]), 32'd1);
    b = st_cnt[1];
    preset = 1'b1;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    chk("mid_rst_busy", 32'(acc_busy), 32'd0);
    chk("mid_rst_start", 32'(acc_start), 32'd0);
    chk("mid_rst_width", 32'(cfg_width), 32'd0);
    @(negedge pclk);
    chk("mid_rst_pulses", 32'(st_cnt[1] - b), 32'd0);
    apb_rd(32'h28, 32'd0, "mid_rst_cycles");
    apb_rd(32'h2C, 32'd0, "mid_rst_cfg");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
